// File: rtl/uart_param_core.sv
// uart_param_core: single-clock UART transmitter and receiver sharing one
// configuration word. Configurable data width, optional parity, one or two
// stop bits, per-direction baud divider and oversampling, 2-of-3 majority
// sampling on RX and break detection.
//
// Handshake: a word is accepted on any CLK edge where TX_VALID && TX_READY;
// TX_DATA and the configuration are latched on that edge and TX_READY drops.
// RX_VALID is a one-cycle pulse with no back-pressure; RX_DATA is held until
// the next completed frame, while the error/break flags last only that cycle.
//
// Debug state encoding (TX_STATE_DBG / RX_STATE_DBG):
// 0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP1, 5 STOP2.
module uart_param_core #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6,
   parameter int DIV_W      = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   input  logic [PRESCALE_W-1:0] PRESCALE,
   input  logic [DIV_W-1:0]      BAUD_DIV,
   input  logic [DATA_WIDTH-1:0] TX_DATA,
   input  logic                  TX_VALID,
   output logic                  TX_READY,
   output logic                  TX_OUT,
   output logic                  TX_BUSY,
   input  logic                  RX_IN,
   output logic [DATA_WIDTH-1:0] RX_DATA,
   output logic                  RX_VALID,
   output logic                  PARITY_ERROR,
   output logic                  STOP_ERROR,
   output logic                  BREAK,
   output logic [2:0]            TX_STATE_DBG,
   output logic [2:0]            RX_STATE_DBG
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP1  = 3'd4,
      S_STOP2  = 3'd5
   } state_e;

   // Effective oversample ratio (at least 4) and divisor (at least 1).
   logic [PRESCALE_W-1:0] p_eff;
   logic [DIV_W-1:0]      d_eff;
   assign p_eff = (PRESCALE < PRESCALE_W'(4)) ? PRESCALE_W'(4) : PRESCALE;
   assign d_eff = (BAUD_DIV == '0) ? DIV_W'(1) : BAUD_DIV;

   // ---------------------------------------------------------------- TX
   state_e                tx_state_q, tx_state_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic                  tx_par_q, tx_par_d;
   logic [CNT_W-1:0]      tx_bit_q, tx_bit_d;
   logic [DIV_W-1:0]      tx_div_q, tx_div_d;
   logic [PRESCALE_W-1:0] tx_os_q, tx_os_d;
   logic [PRESCALE_W-1:0] tx_plim_q, tx_plim_d;
   logic [DIV_W-1:0]      tx_dlim_q, tx_dlim_d;
   logic                  tx_paren_q, tx_paren_d;
   logic                  tx_stop2_q, tx_stop2_d;
   logic                  tx_out_q, tx_out_d;
   logic                  tx_tick, tx_bit_end;

   assign tx_tick    = (tx_div_q == tx_dlim_q);
   assign tx_bit_end = tx_tick && (tx_os_q == tx_plim_q);

   // TX next-state: handshake, bit sequencing and the registered line value.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      tx_bit_d   = tx_bit_q;
      tx_div_d   = tx_div_q;
      tx_os_d    = tx_os_q;
      tx_plim_d  = tx_plim_q;
      tx_dlim_d  = tx_dlim_q;
      tx_paren_d = tx_paren_q;
      tx_stop2_d = tx_stop2_q;
      tx_out_d   = 1'b1;

      if (tx_state_q != S_IDLE) begin
         tx_div_d = tx_tick ? '0 : tx_div_q + 1'b1;
         if (tx_tick) tx_os_d = (tx_os_q == tx_plim_q) ? '0 : tx_os_q + 1'b1;
      end

      case (tx_state_q)
         S_IDLE: begin
            if (TX_VALID) begin
               tx_state_d = S_START;
               tx_shift_d = TX_DATA;
               tx_par_d   = PAR_TYP ? ~^TX_DATA : ^TX_DATA;
               tx_bit_d   = '0;
               tx_div_d   = '0;
               tx_os_d    = '0;
               tx_plim_d  = p_eff - 1'b1;
               tx_dlim_d  = d_eff - 1'b1;
               tx_paren_d = PAR_EN;
               tx_stop2_d = STOP2;
            end
         end
         S_START: if (tx_bit_end) tx_state_d = S_DATA;
         S_DATA: begin
            if (tx_bit_end) begin
               tx_shift_d = tx_shift_q >> 1;
               if (tx_bit_q == CNT_W'(DATA_WIDTH - 1)) tx_state_d = tx_paren_q ? S_PARITY : S_STOP1;
               else tx_bit_d = tx_bit_q + 1'b1;
            end
         end
         S_PARITY: if (tx_bit_end) tx_state_d = S_STOP1;
         S_STOP1:  if (tx_bit_end) tx_state_d = tx_stop2_q ? S_STOP2 : S_IDLE;
         S_STOP2:  if (tx_bit_end) tx_state_d = S_IDLE;
         default:  tx_state_d = S_IDLE;
      endcase

      // Line value follows the state being entered, so TX_OUT is glitch-free.
      case (tx_state_d)
         S_START:  tx_out_d = 1'b0;
         S_DATA:   tx_out_d = tx_shift_d[0];
         S_PARITY: tx_out_d = tx_par_d;
         default:  tx_out_d = 1'b1;
      endcase
   end

   // TX state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         tx_state_q <= S_IDLE;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         tx_bit_q   <= '0;
         tx_div_q   <= '0;
         tx_os_q    <= '0;
         tx_plim_q  <= PRESCALE_W'(3);
         tx_dlim_q  <= '0;
         tx_paren_q <= 1'b0;
         tx_stop2_q <= 1'b0;
         tx_out_q   <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         tx_bit_q   <= tx_bit_d;
         tx_div_q   <= tx_div_d;
         tx_os_q    <= tx_os_d;
         tx_plim_q  <= tx_plim_d;
         tx_dlim_q  <= tx_dlim_d;
         tx_paren_q <= tx_paren_d;
         tx_stop2_q <= tx_stop2_d;
         tx_out_q   <= tx_out_d;
      end
   end

   assign TX_READY     = (tx_state_q == S_IDLE);
   assign TX_BUSY      = (tx_state_q != S_IDLE);
   assign TX_OUT       = tx_out_q;
   assign TX_STATE_DBG = tx_state_q;

   // ---------------------------------------------------------------- RX
   logic                  rx_sync1_q, rx_sync2_q, rx_prev_q;
   state_e                rx_state_q, rx_state_d;
   logic [DIV_W-1:0]      rx_div_q, rx_div_d;
   logic [PRESCALE_W-1:0] rx_os_q, rx_os_d;
   logic [CNT_W-1:0]      rx_bit_q, rx_bit_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [1:0]            rx_v_q, rx_v_d;
   logic                  rx_par_bit_q, rx_par_bit_d;
   logic                  rx_perr_acc_q, rx_perr_acc_d;
   logic                  rx_serr_acc_q, rx_serr_acc_d;
   logic                  rx_szero_q, rx_szero_d;
   logic [PRESCALE_W-1:0] rx_plim_q, rx_plim_d;
   logic [PRESCALE_W-1:0] rx_half_q, rx_half_d;
   logic [DIV_W-1:0]      rx_dlim_q, rx_dlim_d;
   logic                  rx_paren_q, rx_paren_d;
   logic                  rx_partyp_q, rx_partyp_d;
   logic                  rx_stop2_q, rx_stop2_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  rx_perr_q, rx_perr_d;
   logic                  rx_serr_q, rx_serr_d;
   logic                  rx_brk_q, rx_brk_d;
   logic                  rx_tick, rx_bit_end, rx_third, rx_maj, rx_fall, rx_par_exp;
   logic                  rx_fin;

   assign rx_fall    = rx_prev_q & ~rx_sync2_q;
   assign rx_tick    = (rx_div_q == rx_dlim_q);
   assign rx_bit_end = rx_tick && (rx_os_q == rx_plim_q);
   assign rx_third   = rx_tick && (rx_os_q == rx_half_q + 1'b1);
   // Third vote is the live synchronized sample taken at the third index.
   assign rx_maj     = (rx_v_q[0] & rx_v_q[1]) | (rx_v_q[0] & rx_sync2_q) | (rx_v_q[1] & rx_sync2_q);
   assign rx_par_exp = rx_partyp_q ? ~^rx_shift_q : ^rx_shift_q;

   // Synchronizer and edge register; idle-high after reset so no false edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rx_sync1_q <= 1'b1;
         rx_sync2_q <= 1'b1;
         rx_prev_q  <= 1'b1;
      end else begin
         rx_sync1_q <= RX_IN;
         rx_sync2_q <= rx_sync1_q;
         rx_prev_q  <= rx_sync2_q;
      end
   end

   // RX next-state: start detection, majority voting, error and break flags.
   always_comb begin
      rx_state_d    = rx_state_q;
      rx_div_d      = rx_div_q;
      rx_os_d       = rx_os_q;
      rx_bit_d      = rx_bit_q;
      rx_shift_d    = rx_shift_q;
      rx_v_d        = rx_v_q;
      rx_par_bit_d  = rx_par_bit_q;
      rx_perr_acc_d = rx_perr_acc_q;
      rx_serr_acc_d = rx_serr_acc_q;
      rx_szero_d    = rx_szero_q;
      rx_plim_d     = rx_plim_q;
      rx_half_d     = rx_half_q;
      rx_dlim_d     = rx_dlim_q;
      rx_paren_d    = rx_paren_q;
      rx_partyp_d   = rx_partyp_q;
      rx_stop2_d    = rx_stop2_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = 1'b0;
      rx_perr_d     = 1'b0;
      rx_serr_d     = 1'b0;
      rx_brk_d      = 1'b0;
      rx_fin        = 1'b0;

      if (rx_state_q != S_IDLE) begin
         rx_div_d = rx_tick ? '0 : rx_div_q + 1'b1;
         if (rx_tick) rx_os_d = (rx_os_q == rx_plim_q) ? '0 : rx_os_q + 1'b1;
         if (rx_tick && (rx_os_q == rx_half_q - 1'b1)) rx_v_d[0] = rx_sync2_q;
         if (rx_tick && (rx_os_q == rx_half_q)) rx_v_d[1] = rx_sync2_q;
      end

      case (rx_state_q)
         S_IDLE: begin
            if (rx_fall) begin
               rx_state_d    = S_START;
               rx_div_d      = '0;
               rx_os_d       = '0;
               rx_bit_d      = '0;
               rx_v_d        = 2'b11;
               rx_perr_acc_d = 1'b0;
               rx_serr_acc_d = 1'b0;
               rx_szero_d    = 1'b1;
               rx_par_bit_d  = 1'b0;
               rx_plim_d     = p_eff - 1'b1;
               rx_half_d     = p_eff >> 1;
               rx_dlim_d     = d_eff - 1'b1;
               rx_paren_d    = PAR_EN;
               rx_partyp_d   = PAR_TYP;
               rx_stop2_d    = STOP2;
            end
         end
         S_START: begin
            if (rx_third && rx_maj) rx_state_d = S_IDLE;
            else if (rx_bit_end) rx_state_d = S_DATA;
         end
         S_DATA: begin
            if (rx_third) rx_shift_d = {rx_maj, rx_shift_q[DATA_WIDTH-1:1]};
            if (rx_bit_end) begin
               if (rx_bit_q == CNT_W'(DATA_WIDTH - 1)) rx_state_d = rx_paren_q ? S_PARITY : S_STOP1;
               else rx_bit_d = rx_bit_q + 1'b1;
            end
         end
         S_PARITY: begin
            if (rx_third) begin
               rx_par_bit_d  = rx_maj;
               rx_perr_acc_d = (rx_maj != rx_par_exp);
            end
            if (rx_bit_end) rx_state_d = S_STOP1;
         end
         S_STOP1: begin
            if (rx_third) begin
               if (!rx_maj) rx_serr_acc_d = 1'b1;
               else rx_szero_d = 1'b0;
               if (!rx_stop2_q) rx_fin = 1'b1;
            end
            if (!rx_fin && rx_bit_end) rx_state_d = S_STOP2;
         end
         S_STOP2: if (rx_third) rx_fin = 1'b1;
         default: rx_state_d = S_IDLE;
      endcase

      // Final stop sample: publish the frame and go idle for early resync.
      if (rx_fin) begin
         rx_state_d = S_IDLE;
         rx_valid_d = 1'b1;
         rx_data_d  = rx_shift_q;
         rx_perr_d  = rx_perr_acc_q;
         rx_serr_d  = rx_serr_acc_q | ~rx_maj;
         rx_brk_d   = (rx_shift_q == '0) && (!rx_paren_q || !rx_par_bit_q) && rx_szero_q && !rx_maj;
      end
   end

   // RX state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rx_state_q    <= S_IDLE;
         rx_div_q      <= '0;
         rx_os_q       <= '0;
         rx_bit_q      <= '0;
         rx_shift_q    <= '0;
         rx_v_q        <= 2'b11;
         rx_par_bit_q  <= 1'b0;
         rx_perr_acc_q <= 1'b0;
         rx_serr_acc_q <= 1'b0;
         rx_szero_q    <= 1'b1;
         rx_plim_q     <= PRESCALE_W'(3);
         rx_half_q     <= PRESCALE_W'(2);
         rx_dlim_q     <= '0;
         rx_paren_q    <= 1'b0;
         rx_partyp_q   <= 1'b0;
         rx_stop2_q    <= 1'b0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         rx_perr_q     <= 1'b0;
         rx_serr_q     <= 1'b0;
         rx_brk_q      <= 1'b0;
      end else begin
         rx_state_q    <= rx_state_d;
         rx_div_q      <= rx_div_d;
         rx_os_q       <= rx_os_d;
         rx_bit_q      <= rx_bit_d;
         rx_shift_q    <= rx_shift_d;
         rx_v_q        <= rx_v_d;
         rx_par_bit_q  <= rx_par_bit_d;
         rx_perr_acc_q <= rx_perr_acc_d;
         rx_serr_acc_q <= rx_serr_acc_d;
         rx_szero_q    <= rx_szero_d;
         rx_plim_q     <= rx_plim_d;
         rx_half_q     <= rx_half_d;
         rx_dlim_q     <= rx_dlim_d;
         rx_paren_q    <= rx_paren_d;
         rx_partyp_q   <= rx_partyp_d;
         rx_stop2_q    <= rx_stop2_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         rx_perr_q     <= rx_perr_d;
         rx_serr_q     <= rx_serr_d;
         rx_brk_q      <= rx_brk_d;
      end
   end

   assign RX_DATA      = rx_data_q;
   assign RX_VALID     = rx_valid_q;
   assign PARITY_ERROR = rx_perr_q;
   assign STOP_ERROR   = rx_serr_q;
   assign BREAK        = rx_brk_q;
   assign RX_STATE_DBG = rx_state_q;

endmodule

// File: tb/tb_uart_param_core.sv
// Directed testbench for uart_param_core: an 8-bit instance for TX timing,
// loopback, parity error, glitch and break; a 9-bit instance for reset
// during a frame followed by a clean loopback frame.
module tb_uart_param_core;

   logic        clk;
   logic        rst;
   logic        rst9;
   logic        par_en, par_typ, stop2;
   logic [5:0]  prescale;
   logic [15:0] baud_div;

   logic [7:0]  tx_data8;
   logic        tx_valid8, tx_ready8, tx_out8, tx_busy8;
   logic        rx_in8, rx_drv, loop_en, flip;
   logic [7:0]  rx_data8;
   logic        rx_valid8, perr8, serr8, brk8;
   logic [2:0]  tx_st8, rx_st8;

   logic [8:0]  tx_data9;
   logic        tx_valid9, tx_ready9, tx_out9, tx_busy9;
   logic [8:0]  rx_data9;
   logic        rx_valid9, perr9, serr9, brk9;
   logic [2:0]  tx_st9, rx_st9;
   logic        rst_any9;

   int          n_checks = 0;
   int          n_err = 0;
   int          rx_cnt = 0;
   int          rx9_cnt = 0;
   logic [10:0] exp_q[$];
   logic [10:0] mon_exp;

   assign rx_in8   = loop_en ? (tx_out8 ^ flip) : rx_drv;
   assign rst_any9 = rst | rst9;

   uart_param_core #(.DATA_WIDTH(8), .PRESCALE_W(6), .DIV_W(16)) u8 (
      .CLK(clk), .RST(rst), .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
      .PRESCALE(prescale), .BAUD_DIV(baud_div),
      .TX_DATA(tx_data8), .TX_VALID(tx_valid8), .TX_READY(tx_ready8),
      .TX_OUT(tx_out8), .TX_BUSY(tx_busy8), .RX_IN(rx_in8),
      .RX_DATA(rx_data8), .RX_VALID(rx_valid8), .PARITY_ERROR(perr8),
      .STOP_ERROR(serr8), .BREAK(brk8), .TX_STATE_DBG(tx_st8), .RX_STATE_DBG(rx_st8)
   );

   uart_param_core #(.DATA_WIDTH(9), .PRESCALE_W(6), .DIV_W(16)) u9 (
      .CLK(clk), .RST(rst_any9), .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
      .PRESCALE(prescale), .BAUD_DIV(baud_div),
      .TX_DATA(tx_data9), .TX_VALID(tx_valid9), .TX_READY(tx_ready9),
      .TX_OUT(tx_out9), .TX_BUSY(tx_busy9), .RX_IN(tx_out9),
      .RX_DATA(rx_data9), .RX_VALID(rx_valid9), .PARITY_ERROR(perr9),
      .STOP_ERROR(serr9), .BREAK(brk9), .TX_STATE_DBG(tx_st9), .RX_STATE_DBG(rx_st9)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard for the 8-bit receiver: every RX_VALID must match the queue head.
   always @(negedge clk) begin
      if (rx_valid8) begin
         rx_cnt++;
         chk("rx_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            chk("rx_data", 32'(rx_data8), 32'(mon_exp[7:0]));
            chk("rx_parity_err", 32'(perr8), 32'(mon_exp[8]));
            chk("rx_stop_err", 32'(serr8), 32'(mon_exp[9]));
            chk("rx_break", 32'(brk8), 32'(mon_exp[10]));
         end
      end
      if (rx_valid9) rx9_cnt++;
   end

   // Single-word send on the 8-bit instance; returns on the first frame cycle.
   task automatic send8(input logic [7:0] d);
      tx_data8  = d;
      tx_valid8 = 1'b1;
      @(negedge clk);
      tx_valid8 = 1'b0;
   endtask

   // Walks a whole frame cycle by cycle against a hand-written bit vector.
   task automatic tx_frame(input string tag, input logic [15:0] vec, input int n, input int t);
      for (int i = 0; i < n * t; i++) begin
         chk({tag, "_out"}, 32'(tx_out8), 32'(vec[i / t]));
         chk({tag, "_ready"}, 32'(tx_ready8), 32'd0);
         @(negedge clk);
      end
      chk({tag, "_ready_back"}, 32'(tx_ready8), 32'd1);
      chk({tag, "_busy_back"}, 32'(tx_busy8), 32'd0);
   endtask

   // Keeps TX_VALID high; waits for acceptance and checks the one-cycle gap.
   task automatic send_hold(input logic [7:0] d, input bit check_gap);
      int guard;
      guard     = 0;
      tx_data8  = d;
      tx_valid8 = 1'b1;
      while (!tx_ready8 && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      if (check_gap) chk("b2b_gap_high", 32'(tx_out8), 32'd1);
      @(negedge clk);
      chk("b2b_accepted", 32'(tx_ready8), 32'd0);
      chk("b2b_start_low", 32'(tx_out8), 32'd0);
   endtask

   task automatic wait_rx(input int target, input int budget);
      int g;
      g = 0;
      while (rx_cnt < target && g < budget) begin
         @(negedge clk);
         g++;
      end
   endtask

   initial begin
      int base;
      int g;
      rst = 1'b1; rst9 = 1'b0;
      par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
      prescale = 6'd8; baud_div = 16'd1;
      tx_data8 = '0; tx_valid8 = 1'b0; tx_data9 = '0; tx_valid9 = 1'b0;
      rx_drv = 1'b1; loop_en = 1'b0; flip = 1'b0;

      // Reset values.
      repeat (3) @(negedge clk);
      chk("rst_tx_out", 32'(tx_out8), 32'd1);
      chk("rst_tx_ready", 32'(tx_ready8), 32'd1);
      chk("rst_tx_busy", 32'(tx_busy8), 32'd0);
      chk("rst_rx_data", 32'(rx_data8), 32'd0);
      chk("rst_rx_valid", 32'(rx_valid8), 32'd0);
      chk("rst_perr", 32'(perr8), 32'd0);
      chk("rst_serr", 32'(serr8), 32'd0);
      chk("rst_break", 32'(brk8), 32'd0);
      chk("rst_tx_state", 32'(tx_st8), 32'd0);
      chk("rst_rx_state", 32'(rx_st8), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // 0xA5, D=1, P=8, 8N1: bits 0,1,0,1,0,0,1,0,1,1 -> 10'h34A, 80 cycles.
      send8(8'hA5);
      tx_frame("tx_a5", 16'h034A, 10, 8);

      // 0x07, D=2, P=8, even parity, two stops: parity 1 -> 12'hE0E, 192 cycles.
      par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b1; baud_div = 16'd2;
      send8(8'h07);
      par_en = 1'b0; stop2 = 1'b0; baud_div = 16'd1;
      tx_frame("tx_07", 16'h0E0E, 12, 16);

      // Loopback, odd parity, back-to-back 0x3C, 0xFF, 0x00.
      par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b0; loop_en = 1'b1;
      @(negedge clk);
      base = rx_cnt;
      exp_q.push_back({3'b000, 8'h3C});
      exp_q.push_back({3'b000, 8'hFF});
      exp_q.push_back({3'b000, 8'h00});
      send_hold(8'h3C, 1'b0);
      send_hold(8'hFF, 1'b1);
      send_hold(8'h00, 1'b1);
      tx_valid8 = 1'b0;
      wait_rx(base + 3, 600);
      chk("loop_count", 32'(rx_cnt - base), 32'd3);
      repeat (60) @(negedge clk);

      // Parity bit (index 9) inverted in flight: 0x5A odd parity sends 1, RX sees 0.
      base = rx_cnt;
      exp_q.push_back({3'b001, 8'h5A});
      send8(8'h5A);
      repeat (72) @(negedge clk);
      flip = 1'b1;
      repeat (8) @(negedge clk);
      flip = 1'b0;
      wait_rx(base + 1, 200);
      chk("perr_count", 32'(rx_cnt - base), 32'd1);
      repeat (20) @(negedge clk);

      // Two-cycle low glitch on idle line: START seen, then false start.
      loop_en = 1'b0; rx_drv = 1'b1; par_en = 1'b0;
      @(negedge clk);
      base = rx_cnt;
      rx_drv = 1'b0;
      repeat (2) @(negedge clk);
      rx_drv = 1'b1;
      @(negedge clk);
      chk("glitch_start_entered", 32'(rx_st8), 32'd1);
      repeat (40) @(negedge clk);
      chk("glitch_back_idle", 32'(rx_st8), 32'd0);
      chk("glitch_no_valid", 32'(rx_cnt - base), 32'd0);

      // Line low for 20 bit times, 8N1: one break frame only.
      base = rx_cnt;
      exp_q.push_back({3'b110, 8'h00});
      rx_drv = 1'b0;
      repeat (160) @(negedge clk);
      chk("break_one_frame", 32'(rx_cnt - base), 32'd1);
      chk("break_rx_idle", 32'(rx_st8), 32'd0);
      chk("break_data_held", 32'(rx_data8), 32'd0);
      rx_drv = 1'b1;
      repeat (30) @(negedge clk);
      chk("break_no_more", 32'(rx_cnt - base), 32'd1);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      // 9-bit instance: 0x1AB with even parity, reset during the data bits.
      par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
      @(negedge clk);
      tx_data9 = 9'h1AB; tx_valid9 = 1'b1;
      @(negedge clk);
      tx_valid9 = 1'b0;
      chk("w9_started", 32'(tx_ready9), 32'd0);
      repeat (30) @(negedge clk);
      rst9 = 1'b1;
      @(negedge clk);
      chk("w9_rst_tx_out", 32'(tx_out9), 32'd1);
      chk("w9_rst_tx_ready", 32'(tx_ready9), 32'd1);
      chk("w9_rst_rx_state", 32'(rx_st9), 32'd0);
      rst9 = 1'b0;
      repeat (150) @(negedge clk);
      chk("w9_no_valid", 32'(rx9_cnt), 32'd0);

      // Follow-up frame 0x0D6 received intact.
      tx_data9 = 9'h0D6; tx_valid9 = 1'b1;
      @(negedge clk);
      tx_valid9 = 1'b0;
      g = 0;
      while (!rx_valid9 && g < 300) begin
         @(negedge clk);
         g++;
      end
      chk("w9_valid", 32'(rx_valid9), 32'd1);
      chk("w9_data", 32'(rx_data9), 32'h0D6);
      chk("w9_perr", 32'(perr9), 32'd0);
      chk("w9_serr", 32'(serr9), 32'd0);
      chk("w9_break", 32'(brk9), 32'd0);
      @(negedge clk);
      chk("w9_valid_pulse", 32'(rx_valid9), 32'd0);
      chk("w9_data_held", 32'(rx_data9), 32'h0D6);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
